// File: rtl/mips_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pipe_if
// Brief    : Decode-side inputs and per-stage control outputs of the MIPS
//            pipeline control carrier, bundled for port connection.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_ctrl_pipe_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [14:0]            ControlSignals;
    logic [4:0]             Rs_ID;
    logic [4:0]             Rt_ID;
    logic [4:0]             Rd_ID;
    logic                   Zero_EX;

    logic [3:0]             ALUOp_EX;
    logic                   ALUSrc_EX;
    logic                   BranchTaken_EX;
    logic                   MemRead_MEM;
    logic                   MemWrite_MEM;
    logic                   RegWrite_MEM;
    logic                   RegWrite_WB;
    logic                   MemtoReg_WB;
    logic                   Jal_WB;
    logic [4:0]             WriteReg_EX;
    logic [4:0]             WriteReg_MEM;
    logic [4:0]             WriteReg_WB;
    logic [1:0]             PCSel_ID;
    logic                   Stall;
    logic                   Flush_IFID;
    logic [COUNT_WIDTH-1:0] StallCount;
    logic [COUNT_WIDTH-1:0] FlushCount;

    // Decoder/datapath side
    modport master (
        output ControlSignals, Rs_ID, Rt_ID, Rd_ID, Zero_EX,
        input  ALUOp_EX, ALUSrc_EX, BranchTaken_EX,
        input  MemRead_MEM, MemWrite_MEM, RegWrite_MEM,
        input  RegWrite_WB, MemtoReg_WB, Jal_WB,
        input  WriteReg_EX, WriteReg_MEM, WriteReg_WB,
        input  PCSel_ID, Stall, Flush_IFID, StallCount, FlushCount
    );

    // Control carrier side
    modport slave (
        input  ControlSignals, Rs_ID, Rt_ID, Rd_ID, Zero_EX,
        output ALUOp_EX, ALUSrc_EX, BranchTaken_EX,
        output MemRead_MEM, MemWrite_MEM, RegWrite_MEM,
        output RegWrite_WB, MemtoReg_WB, Jal_WB,
        output WriteReg_EX, WriteReg_MEM, WriteReg_WB,
        output PCSel_ID, Stall, Flush_IFID, StallCount, FlushCount
    );
endinterface
`default_nettype wire

// File: rtl/mips_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pipe
// Brief    : Carries the decode control bundle through ID/EX, EX/MEM, MEM/WB
//            and generates load-use stalls, branch squashes and jump redirects.
//            Optional macro MIPS_CTRL_PIPE_PERF_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_pipe #(
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mips_ctrl_pipe_if.slave  bus
);

    localparam int c_JR       = 14;
    localparam int c_JAL      = 13;
    localparam int c_JUMP     = 12;
    localparam int c_REGDST   = 11;
    localparam int c_ALUSRC   = 10;
    localparam int c_MEMTOREG = 9;
    localparam int c_REGWRITE = 8;
    localparam int c_MEMREAD  = 7;
    localparam int c_MEMWRITE = 6;
    localparam int c_BRNE     = 5;
    localparam int c_BREQ     = 4;

    localparam logic [1:0] c_PC_SEQ  = 2'b00;
    localparam logic [1:0] c_PC_JUMP = 2'b01;
    localparam logic [1:0] c_PC_JR   = 2'b10;
    localparam logic [4:0] c_RA      = 5'd31;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       jal;
        logic [4:0] wreg;
    } exmem_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       jal;
        logic [4:0] wreg;
    } memwb_t;

    logic [14:0] idex_ctrl_q, idex_ctrl_d;
    logic [4:0]  idex_wreg_q, idex_wreg_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    logic [4:0]  w_id_wreg;
    logic        w_hazard;
    logic        w_branch_taken;
    logic        w_stall;
    logic        w_flush;
    logic [1:0]  w_pcsel;
    logic        w_unused_ex;

    // Jal forces the link register regardless of RegDst.
    always_comb begin
        w_id_wreg = bus.Rt_ID;
        if (bus.ControlSignals[c_JAL]) begin
            w_id_wreg = c_RA;
        end else if (bus.ControlSignals[c_REGDST]) begin
            w_id_wreg = bus.Rd_ID;
        end
    end

    // Rt is compared even for opcodes that do not read it.
    assign w_hazard = idex_ctrl_q[c_MEMREAD]
                    & (idex_wreg_q != 5'd0)
                    & ((idex_wreg_q == bus.Rs_ID) | (idex_wreg_q == bus.Rt_ID));

    assign w_branch_taken = (idex_ctrl_q[c_BREQ] &  bus.Zero_EX)
                          | (idex_ctrl_q[c_BRNE] & ~bus.Zero_EX);

    always_comb begin
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        w_pcsel     = c_PC_SEQ;
        idex_ctrl_d = bus.ControlSignals;
        idex_wreg_d = w_id_wreg;
        if (w_branch_taken) begin
            w_flush     = 1'b1;
            idex_ctrl_d = '0;
            idex_wreg_d = '0;
        end else if (w_hazard) begin
            // IF/ID is held, so a jump in ID is simply seen again next cycle.
            w_stall     = 1'b1;
            idex_ctrl_d = '0;
            idex_wreg_d = '0;
        end else if (bus.ControlSignals[c_JUMP] | bus.ControlSignals[c_JAL]) begin
            w_pcsel = c_PC_JUMP;
            w_flush = 1'b1;
        end else if (bus.ControlSignals[c_JR]) begin
            w_pcsel = c_PC_JR;
            w_flush = 1'b1;
        end
    end

    always_comb begin
        exmem_d.memread  = idex_ctrl_q[c_MEMREAD];
        exmem_d.memwrite = idex_ctrl_q[c_MEMWRITE];
        exmem_d.regwrite = idex_ctrl_q[c_REGWRITE];
        exmem_d.memtoreg = idex_ctrl_q[c_MEMTOREG];
        exmem_d.jal      = idex_ctrl_q[c_JAL];
        exmem_d.wreg     = idex_wreg_q;

        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.jal      = exmem_q.jal;
        memwb_d.wreg     = exmem_q.wreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_ctrl_q <= '0;
            idex_wreg_q <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
        end else begin
            idex_ctrl_q <= idex_ctrl_d;
            idex_wreg_q <= idex_wreg_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
        end
    end

    // Jump-type bits are consumed in ID; the EX copy only completes the bundle.
    assign w_unused_ex = &{1'b0, idex_ctrl_q[c_JR], idex_ctrl_q[c_JUMP], idex_ctrl_q[c_REGDST]};

    assign bus.ALUOp_EX       = idex_ctrl_q[3:0];
    assign bus.ALUSrc_EX      = idex_ctrl_q[c_ALUSRC];
    assign bus.WriteReg_EX    = idex_wreg_q;
    assign bus.BranchTaken_EX = w_branch_taken;
    assign bus.MemRead_MEM    = exmem_q.memread;
    assign bus.MemWrite_MEM   = exmem_q.memwrite;
    assign bus.RegWrite_MEM   = exmem_q.regwrite;
    assign bus.WriteReg_MEM   = exmem_q.wreg;
    assign bus.RegWrite_WB    = memwb_q.regwrite;
    assign bus.MemtoReg_WB    = memwb_q.memtoreg;
    assign bus.Jal_WB         = memwb_q.jal;
    assign bus.WriteReg_WB    = memwb_q.wreg;
    assign bus.PCSel_ID       = w_pcsel;
    assign bus.Stall          = w_stall;
    assign bus.Flush_IFID     = w_flush;

`ifdef MIPS_CTRL_PIPE_PERF_EN
    logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: they stick at all-ones until reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + COUNT_WIDTH'(1);
        end
        if (w_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.StallCount = stall_cnt_q;
    assign bus.FlushCount = flush_cnt_q;
`else
    assign bus.StallCount = '0;
    assign bus.FlushCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_ctrl_pipe
// Brief    : Self-checking bench for mips_ctrl_pipe; expected stage contents
//            are queued at issue and retired when they reach WB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_ctrl_pipe;

`ifdef MIPS_CTRL_PIPE_PERF_EN
    // Narrow counters keep the saturation run short.
    localparam int CW = 10;
`else
    localparam int CW = 16;
`endif

    localparam logic [14:0] NOP  = 15'h0000;
    localparam logic [14:0] ADDI = 15'h0500;
    localparam logic [14:0] LW   = 15'h0784;
    localparam logic [14:0] RTY  = 15'h0907;
    localparam logic [14:0] BEQ  = 15'h0016;
    localparam logic [14:0] BNE  = 15'h0028;
    localparam logic [14:0] JAL  = 15'h2d00;
    localparam logic [14:0] JR   = 15'h4907;
    localparam logic [14:0] JMP  = 15'h1000;
    localparam logic [14:0] LDBR = 15'h0090;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       jal;
        logic [4:0] wreg;
    } stage_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;
    stage_t exp_q[$];

    always #5 clk = ~clk;

    mips_ctrl_pipe_if #(.COUNT_WIDTH(CW)) bus ();

    mips_ctrl_pipe #(.COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic stage_t mk(input logic [14:0] cs, input logic [4:0] rt, input logic [4:0] rd);
        stage_t e;
        e.aluop    = cs[3:0];
        e.alusrc   = cs[10];
        e.memread  = cs[7];
        e.memwrite = cs[6];
        e.regwrite = cs[8];
        e.memtoreg = cs[9];
        e.jal      = cs[13];
        e.wreg     = cs[13] ? 5'd31 : (cs[11] ? rd : rt);
        return e;
    endfunction

    task automatic sb_reset();
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    // Drives one ID instruction, checks same-cycle control, then checks all
    // three stages after the edge and retires the WB entry.
    task automatic cycle(input logic [14:0] cs, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic zero, input logic e_stall,
                         input logic e_br, input logic [1:0] e_pcsel, input logic e_flush,
                         input string tag);
        stage_t wb, mem, ex;
        bus.ControlSignals = cs;
        bus.Rs_ID = rs;
        bus.Rt_ID = rt;
        bus.Rd_ID = rd;
        bus.Zero_EX = zero;
        #1;
        checks++;
        if ({bus.Stall, bus.BranchTaken_EX, bus.PCSel_ID, bus.Flush_IFID} !== {e_stall, e_br, e_pcsel, e_flush})
            $display("FAIL %s ctrl: got stall/br/pcsel/flush=%b/%b/%b/%b want %b/%b/%b/%b", tag,
                     bus.Stall, bus.BranchTaken_EX, bus.PCSel_ID, bus.Flush_IFID, e_stall, e_br, e_pcsel, e_flush);
        else passed++;
        exp_q.push_back((e_stall || e_br) ? stage_t'('0) : mk(cs, rt, rd));
        @(posedge clk);
        #1;
        wb  = exp_q.pop_front();
        mem = exp_q[0];
        ex  = exp_q[1];
        checks++;
        if ({bus.ALUOp_EX, bus.ALUSrc_EX, bus.WriteReg_EX} !== {ex.aluop, ex.alusrc, ex.wreg})
            $display("FAIL %s ex: got aluop/alusrc/wreg=%h/%b/%0d want %h/%b/%0d", tag,
                     bus.ALUOp_EX, bus.ALUSrc_EX, bus.WriteReg_EX, ex.aluop, ex.alusrc, ex.wreg);
        else passed++;
        checks++;
        if ({bus.MemRead_MEM, bus.MemWrite_MEM, bus.RegWrite_MEM, bus.WriteReg_MEM} !==
            {mem.memread, mem.memwrite, mem.regwrite, mem.wreg})
            $display("FAIL %s mem: got rd/wr/rw/wreg=%b/%b/%b/%0d want %b/%b/%b/%0d", tag,
                     bus.MemRead_MEM, bus.MemWrite_MEM, bus.RegWrite_MEM, bus.WriteReg_MEM,
                     mem.memread, mem.memwrite, mem.regwrite, mem.wreg);
        else passed++;
        checks++;
        if ({bus.RegWrite_WB, bus.MemtoReg_WB, bus.Jal_WB, bus.WriteReg_WB} !==
            {wb.regwrite, wb.memtoreg, wb.jal, wb.wreg})
            $display("FAIL %s wb: got rw/m2r/jal/wreg=%b/%b/%b/%0d want %b/%b/%b/%0d", tag,
                     bus.RegWrite_WB, bus.MemtoReg_WB, bus.Jal_WB, bus.WriteReg_WB,
                     wb.regwrite, wb.memtoreg, wb.jal, wb.wreg);
        else passed++;
    endtask

    task automatic test_reset();
        bus.ControlSignals = JAL;
        bus.Rs_ID = 5'd3;
        bus.Rt_ID = 5'd4;
        bus.Rd_ID = 5'd5;
        bus.Zero_EX = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.ALUOp_EX, bus.ALUSrc_EX, bus.MemRead_MEM, bus.MemWrite_MEM, bus.RegWrite_MEM,
             bus.RegWrite_WB, bus.MemtoReg_WB, bus.Jal_WB, bus.WriteReg_EX, bus.WriteReg_MEM,
             bus.WriteReg_WB, bus.StallCount, bus.FlushCount} !== '0)
            $display("FAIL reset_regs: got ex=%h mem=%0d wb=%0d want all 0",
                     bus.ALUOp_EX, bus.WriteReg_MEM, bus.WriteReg_WB);
        else passed++;
        checks++;
        if ({bus.Stall, bus.BranchTaken_EX, bus.PCSel_ID, bus.Flush_IFID} !== 5'b00011)
            $display("FAIL reset_comb: got stall/br/pcsel/flush=%b/%b/%b/%b want 0/0/01/1",
                     bus.Stall, bus.BranchTaken_EX, bus.PCSel_ID, bus.Flush_IFID);
        else passed++;
        reset = 1'b1;
        sb_reset();
        cycle(ADDI, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "addi");
        checks++;
        if ({bus.WriteReg_EX, bus.ALUSrc_EX} !== {5'd5, 1'b1})
            $display("FAIL addi_ex: got wreg=%0d alusrc=%b want 5 1", bus.WriteReg_EX, bus.ALUSrc_EX);
        else passed++;
        cycle(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "addi_n1");
        cycle(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "addi_n2");
        checks++;
        if (bus.RegWrite_WB !== 1'b1)
            $display("FAIL addi_wb: got RegWrite_WB=%b want 1", bus.RegWrite_WB);
        else passed++;
        // Mid-cycle reset discards in-flight control immediately.
        cycle(LW,   5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "mid_lw");
        cycle(ADDI, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "mid_addi");
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.ALUOp_EX, bus.ALUSrc_EX, bus.MemRead_MEM, bus.RegWrite_MEM, bus.RegWrite_WB,
             bus.MemtoReg_WB, bus.WriteReg_EX, bus.WriteReg_MEM, bus.WriteReg_WB} !== '0)
            $display("FAIL midreset_regs: got wreg ex/mem/wb=%0d/%0d/%0d want 0/0/0",
                     bus.WriteReg_EX, bus.WriteReg_MEM, bus.WriteReg_WB);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_reset();
    endtask

    task automatic test_load_use();
        cycle(LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_lw");
        cycle(RTY, 5'd8, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "lu_stall");
        cycle(RTY, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_go");
        checks++;
        if ({bus.ALUOp_EX, bus.WriteReg_EX} !== {4'h7, 5'd3})
            $display("FAIL lu_late: got aluop=%h wreg=%0d want 7 3", bus.ALUOp_EX, bus.WriteReg_EX);
        else passed++;
        cycle(LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_lw_rt");
        cycle(RTY, 5'd1, 5'd8, 5'd4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "lu_rt_stall");
        cycle(RTY, 5'd1, 5'd8, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_rt_go");
        cycle(LW,  5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_lw_r0");
        cycle(RTY, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_r0_nostall");
        cycle(ADDI, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_addi");
        cycle(RTY, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "lu_noload");
    endtask

    task automatic test_branch();
        cycle(BEQ,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "beq_id");
        cycle(ADDI, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, "beq_taken");
        cycle(BEQ,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "beq_id2");
        cycle(ADDI, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "beq_not");
        cycle(BNE,  5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "bne_id");
        cycle(ADDI, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, "bne_taken");
        cycle(BNE,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "bne_id2");
        cycle(ADDI, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "bne_not");
    endtask

    task automatic test_jumps();
        cycle(JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "jal");
        cycle(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "jal_n1");
        cycle(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "jal_n2");
        checks++;
        if ({bus.WriteReg_WB, bus.Jal_WB, bus.RegWrite_WB} !== {5'd31, 1'b1, 1'b1})
            $display("FAIL jal_wb: got wreg=%0d jal=%b rw=%b want 31 1 1",
                     bus.WriteReg_WB, bus.Jal_WB, bus.RegWrite_WB);
        else passed++;
        cycle(JR,  5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, "jr");
        cycle(JMP, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "jump");
        cycle(NOP, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "jump_n");
    endtask

    task automatic test_simultaneous();
        cycle(LDBR, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "sim_ldbr");
        cycle(JMP,  5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, "sim_br_wins");
        cycle(LW,   5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "sim_lw");
        cycle(JMP,  5'd8, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "sim_jmp_held");
        cycle(JMP,  5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "sim_jmp_go");
        cycle(NOP,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "sim_n");
    endtask

    task automatic test_counters();
        logic [CW-1:0] e_stall_cnt;
        logic [CW-1:0] e_flush_cnt;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "cnt_lw");
            cycle(RTY, 5'd8, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "cnt_stall");
            cycle(RTY, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "cnt_go");
        end
        for (int i = 0; i < 2; i++) begin
            cycle(JMP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, "cnt_jmp");
            cycle(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "cnt_nop");
        end
`ifdef MIPS_CTRL_PIPE_PERF_EN
        e_stall_cnt = CW'(3);
        e_flush_cnt = CW'(2);
`else
        e_stall_cnt = '0;
        e_flush_cnt = '0;
`endif
        checks++;
        if ({bus.StallCount, bus.FlushCount} !== {e_stall_cnt, e_flush_cnt})
            $display("FAIL counters: got stall=%0d flush=%0d want %0d %0d",
                     bus.StallCount, bus.FlushCount, e_stall_cnt, e_flush_cnt);
        else passed++;
`ifdef MIPS_CTRL_PIPE_PERF_EN
        for (int i = 0; i < (1 << CW); i++) begin
            cycle(LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "sat_lw");
            cycle(RTY, 5'd8, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "sat_stall");
        end
        checks++;
        if ({bus.StallCount, bus.FlushCount} !== {{CW{1'b1}}, e_flush_cnt})
            $display("FAIL saturate: got stall=%0d flush=%0d want %0d %0d",
                     bus.StallCount, bus.FlushCount, {CW{1'b1}}, e_flush_cnt);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_jumps();
        test_simultaneous();
        test_counters();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_ctrl_pipe.md
# mips_ctrl_pipe

Pipeline control carrier for the 5-stage MIPS core. It consumes the 15-bit control bundle produced by the decode-stage control unit and carries each field to the stage that uses it. It generates bubbles and squashes for load-use hazards, for taken branches resolved in EX, and for jumps resolved in ID. It sits between the decoder and the datapath stage registers, and owns the control half of the ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- COUNT_WIDTH, 16, width of the performance counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ControlSignals  in  15  decode bundle, with fields:
  - [14] Jr, [13] Jal, [12] Jump, [11] RegDst, [10] ALUSrc
  - [9] MemtoReg, [8] RegWrite, [7] MemRead, [6] MemWrite
  - [5] BranchNE, [4] BranchEQ, [3:0] ALUOp
- Rs_ID, Rt_ID, Rd_ID  in  5 each  register fields of the instruction in ID
- Zero_EX  in  1  ALU zero flag of the instruction in EX
- ALUOp_EX  out  4; ALUSrc_EX  out  1
- BranchTaken_EX  out  1  redirect PC to the branch target
- MemRead_MEM, MemWrite_MEM, RegWrite_MEM  out  1 each
- RegWrite_WB, MemtoReg_WB, Jal_WB  out  1 each
- WriteReg_EX, WriteReg_MEM, WriteReg_WB  out  5 each  destination register per stage
- PCSel_ID  out  2  PC source:
  - 00 sequential, 01 Jump/Jal target, 10 Jr (Rs value)
- Stall  out  1  hold PC and IF/ID
- Flush_IFID  out  1  load a nop into IF/ID
- StallCount, FlushCount  out  COUNT_WIDTH each  performance counters

## Operation
- Stage registers:
  - ID/EX holds the full bundle plus the resolved destination register.
  - EX/MEM holds MemRead, MemWrite, RegWrite, MemtoReg, Jal and the destination.
  - MEM/WB holds RegWrite, MemtoReg, Jal and the destination.
- Destination resolution in ID:
  - Jal gives 31.
  - Otherwise RegDst=1 gives Rd_ID, else Rt_ID.
- Load-use hazard, combinational:
  - hazard = MemRead_EX & (WriteReg_EX != 0) & (WriteReg_EX == Rs_ID | WriteReg_EX == Rt_ID).
  - Rt is compared for every opcode (conservative).
- BranchTaken_EX = (BranchEQ_EX & Zero_EX) | (BranchNE_EX & ~Zero_EX).
- Priority, highest first:
  1. BranchTaken_EX: Flush_IFID=1, ID/EX loads zero (bubble), Stall=0, PCSel_ID=00. Any hazard or jump in ID is discarded.
  2. Hazard: Stall=1, ID/EX loads zero, Flush_IFID=0, PCSel_ID=00. A jump in ID is deferred until the stall clears.
  3. Jump or Jal in ID: PCSel_ID=01, Flush_IFID=1. Jr in ID: PCSel_ID=10, Flush_IFID=1. The jump itself proceeds into ID/EX, so Jal writes r31.
  4. Otherwise ID/EX loads ControlSignals.
- EX/MEM and MEM/WB always advance; they are never stalled.
- A zero bundle is a nop: no writes and no memory access.

## Timing
- On reset assertion, asynchronously:
  - All stage registers clear to 0.
  - Every registered output is 0.
  - Counters are 0.
- While reset is held, and therefore with stage registers zero:
  - Stall and BranchTaken_EX are 0.
  - PCSel_ID and Flush_IFID follow the ID inputs.
- Reset mid-operation discards all in-flight control immediately, with no partial writeback.
- Stall, Flush_IFID, PCSel_ID and BranchTaken_EX are combinational in the same cycle. All other outputs are registered.
- Latency: a field decoded in ID cycle N appears at _EX in N+1, _MEM in N+2 and _WB in N+3.
- Hazard stall lasts exactly 1 cycle. The load advances to MEM, so hazard falls.
- Penalties:
  - Taken branch costs 2 bubbles: IF/ID flushed and ID/EX zeroed.
  - Jump costs 1 bubble.
- WriteReg_EX == 0 never stalls.

## Configuration
- MIPS_CTRL_PIPE_PERF_EN
  - Defined:
    - StallCount increments once per cycle with Stall=1.
    - FlushCount increments once per cycle with Flush_IFID=1.
    - Both counters saturate at all-ones and clear only on reset.
  - Undefined: StallCount and FlushCount are constant 0 and no counter flops exist.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** reset=0 with nonzero ControlSignals → every registered output is 0. Release reset and drive the ADDI bundle 0x0500 with Rt=5 → WriteReg_EX=5, ALUSrc_EX=1 the next cycle, RegWrite_WB=1 three cycles later.
- **Load-use:** LW bundle 0x0784 with Rt=8, then R-type bundle 0x0907 with Rs=8 → Stall=1 for exactly one cycle, ID/EX bubble (ALUOp_EX=0), dependent op reaches EX one cycle late. Same sequence with Rt=0 → no stall.
- **Branch:** BEQ 0x0016 in EX with Zero_EX=1 → BranchTaken_EX=1 and Flush_IFID=1 that cycle, ID/EX zero next cycle. With Zero_EX=0 → no redirect. BNE 0x0028 with Zero_EX=0 → taken.
- **Jumps:** Jal 0x2d00 in ID → PCSel_ID=01, Flush_IFID=1, WriteReg_WB=31 and Jal_WB=1 three cycles later. R-type 0x4907 with Funct=8 (Jr) → PCSel_ID=10.
- **Simultaneous events:**
  - Taken branch in EX while ID holds a load-use dependent Jump → Stall=0, PCSel_ID=00, Flush_IFID=1.
  - Hazard plus Jump in ID → PCSel_ID=00 during the stall, then 01.
- **Counters:** with MIPS_CTRL_PIPE_PERF_EN defined, 3 stalls and 2 flushes → StallCount=3, FlushCount=2. Force 2^COUNT_WIDTH stalls → StallCount holds 0xFFFF. With the macro undefined → both counters read 0.
